cache_ctrl: RTL and testbench
=============================

Name: cache_ctrl

Overview:
Lookup/refill controller for the set-associative tag store. It accepts one CPU address request at a time and reads all ways' tags at the request index. It checks them against per-way valid bits it owns, then reports hit/miss and the hit way. On a miss it picks a victim way, runs a memory refill handshake, and writes the new tag into the tag store. It also keeps saturating hit and miss counters for performance analysis.

Parameters:
WIDTH, 8, tag width in bits
WAYS, 4, associativity (power of 2, >=2)
TOTAL_SIZE, 16, total lines; SETS = TOTAL_SIZE/WAYS; IDX_W = $clog2(SETS); WAY_W = $clog2(WAYS)
CNT_W, 16, width of the hit and miss counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
cpu_valid  in  1  request valid
cpu_ready  out  1  controller can accept a request
cpu_addr  in  WIDTH+IDX_W  {tag, index}; index = low IDX_W bits
flush  in  1  invalidate all lines
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  1 = hit, 0 = filled after miss
resp_way  out  WAY_W  way holding the line
tag_we  out  1  tag store write enable
tag_way  out  WAY_W  tag store way select
tag_index  out  IDX_W  tag store index
tag_wdata  out  WIDTH  tag to write
tag_rdata  in  WAYS*WIDTH  tags of all ways at tag_index; way w = bits [w*WIDTH +: WIDTH]; combinational
mem_req  out  1  refill request
mem_addr  out  WIDTH+IDX_W  refill address
mem_ack  in  1  refill complete, single-cycle pulse
hit_count  out  CNT_W  saturating hit counter
miss_count  out  CNT_W  saturating miss counter

Behaviour:
- Reset (async): state=IDLE; all valid bits 0; all round-robin pointers 0; captured address 0; counters 0. Outputs during reset: cpu_ready=1; resp_valid, resp_hit, resp_way, tag_we, mem_req = 0; tag_way, tag_index, tag_wdata, mem_addr = 0.
- States: IDLE, LOOKUP, MISS_REQ, FILL, RESP.
- IDLE: cpu_ready=1.
  - flush=1: clear all valid bits at the clock edge, stay in IDLE. Flush has priority over cpu_valid; a request presented in the same cycle is not accepted (cpu_ready=0 in any cycle with flush=1).
  - Otherwise, cpu_valid & cpu_ready: capture cpu_addr, go to LOOKUP.
  - flush outside IDLE is ignored.
- LOOKUP: tag_index = captured index. hit = some way w has valid[w][idx] and tag_rdata way w == captured tag. If several ways match, the lowest w wins.
  - Hit: record way, hit_count++, go to RESP with resp_hit=1.
  - Miss: victim = lowest-index invalid way in the set; if none, the set's round-robin pointer. Record victim, miss_count++, go to MISS_REQ.
- MISS_REQ: mem_req=1 and mem_addr=captured address, held stable until mem_ack. mem_ack in any MISS_REQ cycle, including the first, goes to FILL. mem_ack outside MISS_REQ is ignored.
- FILL: one cycle. tag_we=1, tag_way=victim, tag_index=idx, tag_wdata=captured tag. At the edge: valid[victim][idx]=1. The round-robin pointer advances (mod WAYS) only if the victim came from the pointer. Go to RESP with resp_hit=0.
- RESP: one cycle. resp_valid=1, resp_hit and resp_way held. Go to IDLE.
- tag_way equals the victim in FILL and equals 0 otherwise. tag_index always equals the captured index.
- Latency (request accepted at edge T):
  - Hit: LOOKUP in cycle T+1, resp_valid in cycle T+2.
  - Miss: mem_req from T+2; mem_ack in cycle A; FILL in A+1; resp_valid in A+2.
- Counters saturate at 2^CNT_W-1 and are never cleared except by reset; flush does not clear them.
- Reset mid-operation: returns to IDLE at once. Any pending mem_req drops asynchronously, and all valid bits are lost.

Test Plan:
- Cold miss: reset, request addr {tag=0x12, idx=1}, mem_ack 3 cycles after mem_req -> mem_addr matches the request; tag_we with way 0, index 1, data 0x12; resp_hit=0, resp_way=0; miss_count=1.
- Hit: repeat the same address -> resp_valid exactly 2 cycles after acceptance, resp_hit=1, resp_way=0; hit_count=1; no mem_req issued.
- Replacement: fill idx 2 with tags 0xA0..0xA3 (ways 0..3), then request 0xA4 then 0xA5 -> victims are way 0 then way 1 via round-robin; tag 0xA0 now misses.
- Flush priority: flush and cpu_valid together in IDLE -> cpu_ready=0, request not accepted; next request to a previously filled line misses; counters unchanged by the flush.
- Same-cycle ack: mem_ack in the first MISS_REQ cycle -> FILL next cycle, response 2 cycles after the ack.
- Async reset during MISS_REQ -> mem_req drops with no clock edge; cpu_ready=1; a previously resident line misses afterward.

Source files
------------

// File: rtl/cache_ctrl.sv
// Lookup/refill controller for a set-associative tag store with per-way valid bits.
// Hit: response two cycles after acceptance; miss: response two cycles after mem_ack.
// One request in flight; cpu_ready is high only in IDLE with no flush pending.
module cache_ctrl #(
  parameter int WIDTH      = 8,
  parameter int WAYS       = 4,
  parameter int TOTAL_SIZE = 16,
  parameter int CNT_W      = 16,
  localparam int SETS      = TOTAL_SIZE / WAYS,
  localparam int IDX_W     = $clog2(SETS),
  localparam int WAY_W     = $clog2(WAYS),
  localparam int AW        = WIDTH + IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  output logic                  cpu_ready,
  input  logic [AW-1:0]         cpu_addr,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [WAY_W-1:0]      resp_way,
  output logic                  tag_we,
  output logic [WAY_W-1:0]      tag_way,
  output logic [IDX_W-1:0]      tag_index,
  output logic [WIDTH-1:0]      tag_wdata,
  input  logic [WAYS*WIDTH-1:0] tag_rdata,
  output logic                  mem_req,
  output logic [AW-1:0]         mem_addr,
  input  logic                  mem_ack,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOOKUP   = 3'd1,
    MISS_REQ = 3'd2,
    FILL     = 3'd3,
    RESP     = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [AW-1:0]                   addr_q, addr_d;
  logic [SETS-1:0][WAYS-1:0]       valid_q, valid_d;
  logic [SETS-1:0][WAY_W-1:0]      rr_q, rr_d;
  logic [WAY_W-1:0]                way_q, way_d;
  logic                            hit_q, hit_d;
  logic                            from_rr_q, from_rr_d;
  logic [CNT_W-1:0]                hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]                miss_cnt_q, miss_cnt_d;

  logic [IDX_W-1:0]                idx_q;
  logic [WIDTH-1:0]                tag_q;
  logic                            hit;
  logic [WAY_W-1:0]                hit_way;
  logic                            any_inv;
  logic [WAY_W-1:0]                inv_way;

  assign idx_q = addr_q[IDX_W-1:0];
  assign tag_q = addr_q[AW-1:IDX_W];

  // Tag compare and first-invalid search; descending loop so the lowest way wins.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    any_inv = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[idx_q][w] && (tag_rdata[w*WIDTH +: WIDTH] == tag_q)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[idx_q][w]) begin
        any_inv = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

  // Next-state logic for the controller FSM and its bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    valid_d    = valid_q;
    rr_d       = rr_q;
    way_d      = way_q;
    hit_d      = hit_q;
    from_rr_d  = from_rr_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (cpu_valid) begin
          addr_d  = cpu_addr;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          way_d   = hit_way;
          hit_d   = 1'b1;
          if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
          state_d = RESP;
        end else begin
          // Prefer an empty way; only evict through the pointer when the set is full.
          way_d     = any_inv ? inv_way : rr_q[idx_q];
          from_rr_d = !any_inv;
          hit_d     = 1'b0;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
          state_d   = MISS_REQ;
        end
      end
      MISS_REQ: begin
        if (mem_ack) state_d = FILL;
      end
      FILL: begin
        valid_d[idx_q][way_q] = 1'b1;
        if (from_rr_q) rr_d[idx_q] = rr_q[idx_q] + WAY_W'(1);
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and bookkeeping registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      rr_q       <= '0;
      way_q      <= '0;
      hit_q      <= 1'b0;
      from_rr_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      way_q      <= way_d;
      hit_q      <= hit_d;
      from_rr_q  <= from_rr_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them without a clock.
  assign cpu_ready  = (state_q == IDLE) && !flush;
  assign resp_valid = (state_q == RESP);
  assign resp_hit   = hit_q;
  assign resp_way   = way_q;
  assign tag_we     = (state_q == FILL);
  assign tag_way    = (state_q == FILL) ? way_q : '0;
  assign tag_index  = idx_q;
  assign tag_wdata  = tag_q;
  assign mem_req    = (state_q == MISS_REQ);
  assign mem_addr   = addr_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: tag store modelled here, responses scored against a queue.
module tb_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [9:0]  cpu_addr;
  logic        flush;
  logic        resp_valid;
  logic        resp_hit;
  logic [1:0]  resp_way;
  logic        tag_we;
  logic [1:0]  tag_way;
  logic [1:0]  tag_index;
  logic [7:0]  tag_wdata;
  logic [31:0] tag_rdata;
  logic        mem_req;
  logic [9:0]  mem_addr;
  logic        mem_ack;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb_q[$];   // {hit, way}
  logic [7:0] tmem [4][4];

  always #5 clk = ~clk;

  cache_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
    .flush(flush),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .tag_we(tag_we), .tag_way(tag_way), .tag_index(tag_index),
    .tag_wdata(tag_wdata), .tag_rdata(tag_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Tag store: synchronous write, combinational read of all ways.
  always @(posedge clk) begin
    if (tag_we) tmem[tag_index][tag_way] <= tag_wdata;
  end

  always_comb begin
    tag_rdata = '0;
    for (int w = 0; w < 4; w++) tag_rdata[w*8 +: 8] = tmem[tag_index][w];
  end

  // Response monitor: every resp_valid must match the oldest expected entry.
  always @(negedge clk) begin
    logic [2:0] exp_e;
    if (!rst && resp_valid) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL resp_unexpected: got hit=%0b way=%0d, required no response", resp_hit, resp_way);
      end else begin
        exp_e = sb_q.pop_front();
        if ({resp_hit, resp_way} !== exp_e) begin
          errors++;
          $display("FAIL resp_data: got hit=%0b way=%0d, required hit=%0b way=%0d",
                   resp_hit, resp_way, exp_e[2], exp_e[1:0]);
        end
      end
    end
  end

  task automatic do_req(input logic [9:0] addr, input logic exp_hit,
                        input logic [1:0] exp_way, input int ack_dly, input string name);
    sb_q.push_back({exp_hit, exp_way});
    cpu_addr  = addr;
    cpu_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1) begin
      errors++; $display("FAIL %s_ready: got %0b, required 1", name, cpu_ready);
    end
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    // LOOKUP cycle
    @(negedge clk);
    checks++;
    if (resp_valid !== 1'b0 || mem_req !== 1'b0 || tag_we !== 1'b0) begin
      errors++; $display("FAIL %s_lookup: got resp_valid=%0b mem_req=%0b tag_we=%0b, required 0 0 0",
                         name, resp_valid, mem_req, tag_we);
    end
    if (exp_hit) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || mem_req !== 1'b0) begin
        errors++; $display("FAIL %s_hit_latency: got resp_valid=%0b mem_req=%0b, required 1 0",
                           name, resp_valid, mem_req);
      end
    end else begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== addr) begin
        errors++; $display("FAIL %s_mem_req: got req=%0b addr=%h, required 1 %h", name, mem_req, mem_addr, addr);
      end
      for (int k = 0; k < ack_dly; k++) begin
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== addr) begin
          errors++; $display("FAIL %s_mem_hold: got req=%0b addr=%h, required 1 %h", name, mem_req, mem_addr, addr);
        end
      end
      mem_ack = 1'b1;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      // FILL cycle
      @(negedge clk);
      checks++;
      if (tag_we !== 1'b1 || tag_way !== exp_way || tag_index !== addr[1:0] ||
          tag_wdata !== addr[9:2] || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
        errors++; $display("FAIL %s_fill: got we=%0b way=%0d idx=%0d data=%h req=%0b rv=%0b, required 1 %0d %0d %h 0 0",
                           name, tag_we, tag_way, tag_index, tag_wdata, mem_req, resp_valid,
                           exp_way, addr[1:0], addr[9:2]);
      end
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || tag_we !== 1'b0 || tag_way !== 2'd0) begin
        errors++; $display("FAIL %s_miss_latency: got resp_valid=%0b tag_we=%0b tag_way=%0d, required 1 0 0",
                           name, resp_valid, tag_we, tag_way);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_counts(input logic [15:0] eh, input logic [15:0] em, input string name);
    checks++;
    if (hit_count !== eh || miss_count !== em) begin
      errors++; $display("FAIL %s_counts: got hits=%0d misses=%0d, required %0d %0d",
                         name, hit_count, miss_count, eh, em);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; flush = 1'b0; mem_ack = 1'b0;
    #3;
    checks++;
    if (cpu_ready !== 1'b1 || resp_valid !== 1'b0 || resp_hit !== 1'b0 || resp_way !== 2'd0 ||
        tag_we !== 1'b0 || mem_req !== 1'b0 || tag_way !== 2'd0 || tag_index !== 2'd0 ||
        tag_wdata !== 8'd0 || mem_addr !== 10'd0) begin
      errors++; $display("FAIL reset_outputs: got rdy=%0b rv=%0b hit=%0b way=%0d we=%0b req=%0b tway=%0d idx=%0d wd=%h ma=%h, required 1 and zeros",
                         cpu_ready, resp_valid, resp_hit, resp_way, tag_we, mem_req, tag_way, tag_index, tag_wdata, mem_addr);
    end
    check_counts(16'd0, 16'd0, "reset");
    #19 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss;
    do_req({8'h12, 2'd1}, 1'b0, 2'd0, 3, "cold_miss");
    check_counts(16'd0, 16'd1, "cold_miss");
  endtask

  task automatic test_hit;
    do_req({8'h12, 2'd1}, 1'b1, 2'd0, 0, "hit");
    check_counts(16'd1, 16'd1, "hit");
  endtask

  task automatic test_replacement;
    for (int i = 0; i < 4; i++) begin
      logic [7:0] t;
      t = 8'(8'hA0 + i);
      do_req({t, 2'd2}, 1'b0, 2'(i), 1, "repl_fill");
    end
    do_req({8'hA4, 2'd2}, 1'b0, 2'd0, 2, "repl_rr0");
    do_req({8'hA5, 2'd2}, 1'b0, 2'd1, 2, "repl_rr1");
    do_req({8'hA0, 2'd2}, 1'b0, 2'd2, 1, "repl_evicted");
    do_req({8'hA3, 2'd2}, 1'b1, 2'd3, 0, "repl_survivor");
    check_counts(16'd2, 16'd8, "replacement");
  endtask

  task automatic test_flush;
    flush = 1'b1; cpu_valid = 1'b1; cpu_addr = {8'h12, 2'd1};
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready: got %0b, required 0", cpu_ready);
    end
    @(posedge clk); #1;
    flush = 1'b0; cpu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_ready !== 1'b1 || mem_req !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL flush_not_accepted: got rdy=%0b req=%0b rv=%0b, required 1 0 0",
                         cpu_ready, mem_req, resp_valid);
    end
    check_counts(16'd2, 16'd8, "flush");
    @(posedge clk); #1;
    do_req({8'h12, 2'd1}, 1'b0, 2'd0, 1, "flush_remiss");
    check_counts(16'd2, 16'd9, "flush_remiss");
  endtask

  task automatic test_same_cycle_ack;
    do_req({8'h33, 2'd3}, 1'b0, 2'd0, 0, "ack0");
    check_counts(16'd2, 16'd10, "ack0");
  endtask

  task automatic test_async_reset;
    cpu_addr = {8'h55, 2'd0}; cpu_valid = 1'b1;
    @(posedge clk); #1;
    cpu_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++; $display("FAIL arst_pre_req: got %0b, required 1", mem_req);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (mem_req !== 1'b0 || cpu_ready !== 1'b1) begin
      errors++; $display("FAIL arst_async: got req=%0b rdy=%0b, required 0 1", mem_req, cpu_ready);
    end
    check_counts(16'd0, 16'd0, "arst");
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); #1;
    do_req({8'h12, 2'd1}, 1'b0, 2'd0, 1, "arst_remiss");
    check_counts(16'd0, 16'd1, "arst_remiss");
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_replacement();
    test_flush();
    test_same_cycle_ack();
    test_async_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: got %0d pending responses, required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
